// File: rtl/sqrt_inverse_16bit.sv
// sqrt_inverse_16bit: rebuilds radical = q*q + remainder from a sqrt root/remainder pair.
// Iterative shift-add squarer with a start/busy/done handshake; one iteration per clock,
// QW iterations per result.
// Optional macro SQRT_INV_CHECK_EN: when defined, the invalid output flags pairs with
// remainder > 2*q (not a legal sqrt result). When undefined, invalid is tied to 0.
module sqrt_inverse_16bit #(
    parameter int QW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [QW-1:0]     q,
    input  logic [QW:0]       remainder,
    output logic              busy,
    output logic              done,
    output logic [2*QW-1:0]   radical,
    output logic              overflow,
    output logic              invalid
);

    // Accumulator is one bit wider than the radical so the carry out becomes overflow.
    localparam int AW = 2*QW + 1;
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    logic [0:0]      state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [QW-1:0]   mcand_q,   mcand_d;
    logic [QW-1:0]   mplier_q,  mplier_d;
    logic [AW-1:0]   acc_q,     acc_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;
    logic [2*QW-1:0] radical_q, radical_d;
    logic            ovf_q,     ovf_d;
`ifdef SQRT_INV_CHECK_EN
    logic            inv_pend_q, inv_pend_d;
    logic            inv_q,      inv_d;
`endif

    logic [AW-1:0]   addend;
    logic [AW-1:0]   sum;
    logic            last_iter;

    // Partial product for this iteration and the running sum it produces.
    always_comb begin
        addend    = mplier_q[0] ? (AW'(mcand_q) << cnt_q) : '0;
        sum       = acc_q + addend;
        last_iter = (cnt_q == CW'(QW - 1));
    end

    // Next-state logic: capture in IDLE, one shift-add per cycle in CALC.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        radical_d = radical_q;
        ovf_d     = ovf_q;
`ifdef SQRT_INV_CHECK_EN
        inv_pend_d = inv_pend_q;
        inv_d      = inv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = q;
                    mplier_d = q;
                    acc_d    = AW'(remainder);
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_CALC;
`ifdef SQRT_INV_CHECK_EN
                    // Legal sqrt pairs satisfy remainder <= 2*q.
                    inv_pend_d = (remainder > {q, 1'b0});
`endif
                end
            end
            S_CALC: begin
                acc_d    = sum;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last_iter) begin
                    // Final sum goes straight to the outputs; no extra cycle.
                    radical_d = sum[2*QW-1:0];
                    ovf_d     = sum[2*QW];
`ifdef SQRT_INV_CHECK_EN
                    inv_d     = inv_pend_q;
`endif
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset clears everything and drops any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            radical_q <= '0;
            ovf_q     <= 1'b0;
`ifdef SQRT_INV_CHECK_EN
            inv_pend_q <= 1'b0;
            inv_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            radical_q <= radical_d;
            ovf_q     <= ovf_d;
`ifdef SQRT_INV_CHECK_EN
            inv_pend_q <= inv_pend_d;
            inv_q      <= inv_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign radical  = radical_q;
    assign overflow = ovf_q;
`ifdef SQRT_INV_CHECK_EN
    assign invalid  = inv_q;
`else
    assign invalid  = 1'b0;
`endif

endmodule
